// File: rtl/ax_debounce_pkg.sv
// Shared helpers for the ax_debounce_array key bank: width math, tick period,
// parameter legality and the per-channel event bundle.
package ax_debounce_pkg;

  typedef struct packed {
    logic press;
    logic rel;
    logic short_hold;
    logic long_hold;
    logic rep;
  } key_evt_t;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int tick_cycles(input int clk_freq_mhz);
    return clk_freq_mhz * 1000;
  endfunction

  function automatic bit array_legal(input int ch, input int clk_freq_mhz);
    return (ch >= 1) && (ch <= 32) && (clk_freq_mhz >= 1);
  endfunction

  function automatic bit timing_legal(input int debounce_ms, input int long_ms,
                                      input int repeat_ms);
    return (debounce_ms >= 2) && (long_ms > debounce_ms) && (repeat_ms >= 1);
  endfunction

endpackage

// File: rtl/ax_debounce_chan.sv
// One key channel: 2-flop sync, tick-based debounce, press/release/short/long
// classification and, with AX_DEBOUNCE_REPEAT_EN defined, auto-repeat.
module ax_debounce_chan
  import ax_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  input  logic     key_in,
  output logic     key_out,
  output key_evt_t evt
);

  localparam logic RELEASED = (ACTIVE_LOW != 0);
  localparam int   DEB_W    = clog2(DEBOUNCE_MS + 1);
  localparam int   HOLD_W   = clog2(LONG_MS + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

  if (!timing_legal(DEBOUNCE_MS, LONG_MS, REPEAT_MS)) begin : g_param_check
    $error("ax_debounce_chan: illegal DEBOUNCE_MS/LONG_MS/REPEAT_MS");
  end

  logic              s1;
  logic              s2;
  logic [DEB_W-1:0]  deb_cnt;
  logic              prev_out;
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;
  logic              press_q;
  logic              rel_q;
  logic              short_q;
  logic              long_q;
  logic              rep_q;
  logic              pressed;
  logic              prev_pressed;

  assign pressed      = (key_out != RELEASED);
  assign prev_pressed = (prev_out != RELEASED);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RELEASED;
      s2 <= RELEASED;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // Debounce: a bounce back to the current level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out <= RELEASED;
      deb_cnt <= '0;
    end else if (s2 == key_out) begin
      deb_cnt <= '0;
    end else if (tick) begin
      if (deb_cnt == DEB_LAST) begin
        key_out <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Events are decoded from the level one cycle after it moves, so press and
  // release can never coincide; short uses long_done before it is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_out  <= RELEASED;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      prev_out <= key_out;
      press_q  <= pressed && !prev_pressed;
      rel_q    <= !pressed && prev_pressed;
      short_q  <= !pressed && prev_pressed && !long_done;
      long_q   <= pressed && tick && (hold_cnt == HOLD_LAST);
      if (!pressed) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (tick && (hold_cnt != HOLD_MAX)) begin
        hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) long_done <= 1'b1;
      end
    end
  end

`ifdef AX_DEBOUNCE_REPEAT_EN
  localparam int REP_W = clog2(REPEAT_MS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

  logic [REP_W-1:0] rep_cnt;

  // Repeat period starts counting on the first tick after the long event.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cnt <= '0;
      rep_q   <= 1'b0;
    end else begin
      rep_q <= 1'b0;
      if (!pressed || !long_done) begin
        rep_cnt <= '0;
      end else if (tick) begin
        if (rep_cnt == REP_LAST) begin
          rep_cnt <= '0;
          rep_q   <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign rep_q = 1'b0;
`endif

  assign evt = '{press: press_q, rel: rel_q, short_hold: short_q,
                 long_hold: long_q, rep: rep_q};

endmodule

// File: rtl/ax_debounce_array.sv
// Multi-channel key debouncer with press/release/short/long events on a shared
// 1 ms tick. Define AX_DEBOUNCE_REPEAT_EN to build the auto-repeat counters.
module ax_debounce_array
  import ax_debounce_pkg::*;
#(
  parameter int CH           = 4,
  parameter int CLK_FREQ_MHZ = 50,
  parameter int DEBOUNCE_MS  = 20,
  parameter int LONG_MS      = 1000,
  parameter int REPEAT_MS    = 200,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] key_in,
  output logic [CH-1:0] key_out,
  output logic [CH-1:0] key_press,
  output logic [CH-1:0] key_release,
  output logic [CH-1:0] key_short,
  output logic [CH-1:0] key_long,
  output logic [CH-1:0] key_repeat
);

  localparam int TICK_CYCLES = tick_cycles(CLK_FREQ_MHZ);
  localparam int TICK_W      = clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

  if (!array_legal(CH, CLK_FREQ_MHZ)) begin : g_param_check
    $error("ax_debounce_array: illegal CH/CLK_FREQ_MHZ");
  end

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    key_evt_t evt;

    ax_debounce_chan #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS),
      .REPEAT_MS   (REPEAT_MS),
      .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .key_in  (key_in[c]),
      .key_out (key_out[c]),
      .evt     (evt)
    );

    assign key_press[c]   = evt.press;
    assign key_release[c] = evt.rel;
    assign key_short[c]   = evt.short_hold;
    assign key_long[c]    = evt.long_hold;
    assign key_repeat[c]  = evt.rep;
  end

endmodule
